pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Parametrised successor to the ID-stage control decoder for the five-stage RISC-V core. It sits in the ID stage and performs four jobs:
- decodes the opcode into the existing control set;
- registers that set into an ID/EX control register;
- detects load-use hazards and inserts bubbles;
- sequences a multi-cycle multiply through a stall FSM.

It keeps branch resolution in ID (taken beq flushes IF/ID).

## Interface
- MUL_CYCLES, 4, EX occupancy of a mul in cycles; legal range 1..16
- REG_W, 5, register-address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- opCode_i  in  7  ID-stage opcode
- funct_i  in  10  ID-stage {funct7, funct3}
- rs1_i, rs2_i  in  REG_W  ID-stage source registers
- equal_i  in  1  ID-stage rs1==rs2 compare result
- exRd_i  in  REG_W  destination register of the instruction currently in EX
- exMemRead_i  in  1  EX instruction is a load
- stall_o  out  1  hold PC and IF/ID (combinational)
- branch_o, flush_o  out  1  taken branch; flush IF/ID (combinational)
- mulBusy_o  out  1  FSM in MUL_BUSY (registered)
- aluOp_o  out  2  EX control (registered)
- aluSrc_o, wbDst_o, memRead_o, memWrite_o, memToReg_o, regWrite_o  out  1  EX control (registered)

## Operation
- **Decode (ID, combinational):**
  - R-type 0110011: aluOp 10, aluSrc 0, regWrite 1.
  - I-type 0010011: aluOp 01, aluSrc 1, regWrite 1.
  - Load 0000011: aluOp 00, aluSrc 1, memRead 1, memToReg 1, regWrite 1.
  - Store 0100011: aluOp 00, aluSrc 1, memWrite 1, wbDst 0.
  - Branch 1100011: aluOp 11, aluSrc 0, regWrite 0.
  - wbDst is 1 for everything except store.
  - Any other opcode decodes to all-zero control (no write, no memory access).
- **isMul:** opCode 0110011 and funct_i 0000001000.
- **usesRs2:** R-type, store, or branch.
- **Load-use hazard:** exMemRead_i, exRd_i != 0, and either exRd_i == rs1_i, or usesRs2 and exRd_i == rs2_i.
- **Priority:** MUL_BUSY > load-use > branch.
- **State IDLE:**
  - Load-use hazard: stall_o=1; the EX control register loads zeros (bubble); branch_o=flush_o=0.
  - Otherwise, the EX register loads the decoded set.
  - Branch opcode with equal_i=1: branch_o=flush_o=1.
  - If the loaded instruction isMul and MUL_CYCLES>1: go to MUL_BUSY and set cnt=MUL_CYCLES-1.
- **State MUL_BUSY:**
  - stall_o=1; EX register holds its value; branch_o=flush_o=0.
  - cnt decrements each cycle.
  - When cnt==1 the next state is IDLE.
  - The mul therefore occupies EX for exactly MUL_CYCLES cycles.
- **MUL_CYCLES=1:** no MUL_BUSY entry; mulBusy_o stays 0.
- **cnt:** width $clog2(MUL_CYCLES+1); it never wraps.

## Timing
- **Reset:** all registered outputs 0, state IDLE, cnt 0. stall_o, branch_o, flush_o evaluate to IDLE values.
- **Reset mid-multiply:** reset asserted mid-multiply returns to IDLE asynchronously; the in-flight mul control is cleared.
- **Latency:**
  - Decode to EX outputs: 1 cycle.
  - Stall and flush: 0 cycles (same cycle as ID inputs).
- **Mul stall:** a mul decoded at edge N yields stall_o high for cycles N+1 .. N+MUL_CYCLES-1; mulBusy_o matches this window.
- **Load-use:** stall lasts exactly one cycle. On the following cycle the load has left EX, so the hazard clears without state.
- **Branch during load-use stall:** branch_o is suppressed and re-evaluated next cycle with fresh equal_i.

## Configuration
- **MUL_MULTICYCLE_EN defined:** FSM and counter as above.
- **MUL_MULTICYCLE_EN undefined:**
  - mul is treated as a single-cycle R-type.
  - No FSM or counter logic is built.
  - mulBusy_o is tied 0.
  - MUL_CYCLES is ignored.

## Test plan
- Reset: pulse rst_i with opCode_i=0110011 -> all EX outputs 0; stall_o=0; mulBusy_o=0. After release, next edge gives aluOp_o=10, regWrite_o=1.
- Load-use: exMemRead_i=1, exRd_i=5, rs2_i=5, opCode_i=0100011 -> stall_o=1 one cycle; EX outputs all 0 next edge. Same with exRd_i=0 -> no stall.
- Taken branch: opCode_i=1100011, equal_i=1 -> branch_o=flush_o=1 same cycle. With equal_i=0 -> both 0.
- Mul, MUL_CYCLES=4, macro defined -> stall_o high for 3 cycles after the decode edge; a branch presented during that window gives flush_o=0.
- Async reset asserted in 2nd MUL_BUSY cycle -> mulBusy_o and stall_o drop immediately, not waiting for an edge.
- Macro undefined, same mul -> stall_o never asserts; mulBusy_o=0.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage inputs and EX-stage control outputs of pipe_ctrl_unit, grouped as one bundle.
// The master side drives the ID/EX inputs; the slave side is the control unit itself.
interface pipe_ctrl_unit_if #(
  parameter int REG_W = 5
);
  logic [6:0]       opCode_i;
  logic [9:0]       funct_i;
  logic [REG_W-1:0] rs1_i;
  logic [REG_W-1:0] rs2_i;
  logic             equal_i;
  logic [REG_W-1:0] exRd_i;
  logic             exMemRead_i;
  logic             stall_o;
  logic             branch_o;
  logic             flush_o;
  logic             mulBusy_o;
  logic [1:0]       aluOp_o;
  logic             aluSrc_o;
  logic             wbDst_o;
  logic             memRead_o;
  logic             memWrite_o;
  logic             memToReg_o;
  logic             regWrite_o;

  modport slave (
    input  opCode_i, funct_i, rs1_i, rs2_i, equal_i, exRd_i, exMemRead_i,
    output stall_o, branch_o, flush_o, mulBusy_o, aluOp_o, aluSrc_o, wbDst_o,
           memRead_o, memWrite_o, memToReg_o, regWrite_o
  );

  modport master (
    output opCode_i, funct_i, rs1_i, rs2_i, equal_i, exRd_i, exMemRead_i,
    input  stall_o, branch_o, flush_o, mulBusy_o, aluOp_o, aluSrc_o, wbDst_o,
           memRead_o, memWrite_o, memToReg_o, regWrite_o
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control: opcode decode, ID/EX control register, load-use bubbles, branch flush.
// Define MUL_MULTICYCLE_EN to build the multi-cycle multiply stall FSM; otherwise mul is single-cycle.
//
// state      | meaning
// S_IDLE     | normal decode; load-use bubbles and taken-branch flush evaluated
// S_MUL_BUSY | mul occupying EX; stall, hold EX control, count down remaining cycles
module pipe_ctrl_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int REG_W      = 5
) (
  input logic             clk_i,
  input logic             rst_i,
  pipe_ctrl_unit_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [9:0] FN_MUL    = 10'b0000001000;

  logic [6:0]       op;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] ex_rd;

  assign op    = bus.opCode_i;
  assign rs1   = bus.rs1_i;
  assign rs2   = bus.rs2_i;
  assign ex_rd = bus.exRd_i;

  // ctrl packing: {aluOp[1:0], aluSrc, wbDst, memRead, memWrite, memToReg, regWrite}
  logic [7:0] dec_ctrl;
  logic       uses_rs2;
  logic       is_mul;
  logic       load_use;
  logic       br_taken;

  always_comb begin
    dec_ctrl = '0;
    uses_rs2 = 1'b0;
    case (op)
      OP_R: begin
        dec_ctrl = 8'b10_0_1_0_0_0_1;
        uses_rs2 = 1'b1;
      end
      OP_I:    dec_ctrl = 8'b01_1_1_0_0_0_1;
      OP_LOAD: dec_ctrl = 8'b00_1_1_1_0_1_1;
      OP_STORE: begin
        dec_ctrl = 8'b00_1_0_0_1_0_0;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl = 8'b11_0_1_0_0_0_0;
        uses_rs2 = 1'b1;
      end
      default: dec_ctrl = '0;
    endcase
  end

  assign is_mul   = (op == OP_R) && (bus.funct_i == FN_MUL);
  assign load_use = bus.exMemRead_i && (ex_rd != '0) &&
                    ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));
  assign br_taken = (op == OP_BRANCH) && bus.equal_i;

  logic [7:0] ctrl_q;
  logic [7:0] ctrl_d;
  logic       stall;
  logic       branch;
  logic       mul_busy;

`ifdef MUL_MULTICYCLE_EN
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    stall   = 1'b0;
    branch  = 1'b0;
    if (state_q == S_MUL_BUSY) begin
      stall = 1'b1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = S_IDLE;
      end
    end else if (load_use) begin
      stall  = 1'b1;
      ctrl_d = '0;
    end else begin
      ctrl_d = dec_ctrl;
      branch = br_taken;
      // a one-cycle mul needs no stall window at all
      if (is_mul && (MUL_CYCLES > 1)) begin
        state_d = S_MUL_BUSY;
        cnt_d   = CNT_W'(MUL_CYCLES - 1);
      end
    end
  end

  assign mul_busy = (state_q == S_MUL_BUSY);
`else
  logic unused_mul;
  assign unused_mul = is_mul & (MUL_CYCLES > 0);

  always_comb begin
    ctrl_d = dec_ctrl;
    stall  = 1'b0;
    branch = 1'b0;
    if (load_use) begin
      stall  = 1'b1;
      ctrl_d = '0;
    end else begin
      branch = br_taken;
    end
  end

  assign mul_busy = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.stall_o    = stall;
  assign bus.branch_o   = branch;
  assign bus.flush_o    = branch;
  assign bus.mulBusy_o  = mul_busy;
  assign bus.aluOp_o    = ctrl_q[7:6];
  assign bus.aluSrc_o   = ctrl_q[5];
  assign bus.wbDst_o    = ctrl_q[4];
  assign bus.memRead_o  = ctrl_q[3];
  assign bus.memWrite_o = ctrl_q[2];
  assign bus.memToReg_o = ctrl_q[1];
  assign bus.regWrite_o = ctrl_q[0];

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed steps plus random instruction streams against a cycle model.
// The model follows MUL_MULTICYCLE_EN the same way the design build does.
module tb_pipe_ctrl_unit;

  localparam int MUL_CYCLES = 4;
  localparam int REG_W      = 5;
`ifdef MUL_MULTICYCLE_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [9:0] FN_MUL    = 10'b0000001000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  pipe_ctrl_unit_if #(.REG_W(REG_W)) bus ();

  pipe_ctrl_unit #(.MUL_CYCLES(MUL_CYCLES), .REG_W(REG_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] ctrl_m    = '0;
  int         busy_left = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] obs_ctrl();
    return {bus.aluOp_o, bus.aluSrc_o, bus.wbDst_o, bus.memRead_o,
            bus.memWrite_o, bus.memToReg_o, bus.regWrite_o};
  endfunction

  function automatic logic [7:0] ref_dec(input logic [6:0] op);
    case (op)
      OP_R:      return 8'b10_0_1_0_0_0_1;
      OP_I:      return 8'b01_1_1_0_0_0_1;
      OP_LOAD:   return 8'b00_1_1_1_0_1_1;
      OP_STORE:  return 8'b00_1_0_0_1_0_0;
      OP_BRANCH: return 8'b11_0_1_0_0_0_0;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic bit ref_hazard();
    bit uses2;
    uses2 = (bus.opCode_i == OP_R) || (bus.opCode_i == OP_STORE) || (bus.opCode_i == OP_BRANCH);
    return bus.exMemRead_i && (bus.exRd_i != 0) &&
           ((bus.exRd_i == bus.rs1_i) || (uses2 && (bus.exRd_i == bus.rs2_i)));
  endfunction

  task automatic drive(input logic [6:0] op, input logic [9:0] fn, input int r1, input int r2,
                       input bit eq, input int exrd, input bit exmr);
    bus.opCode_i    = op;
    bus.funct_i     = fn;
    bus.rs1_i       = REG_W'(r1);
    bus.rs2_i       = REG_W'(r2);
    bus.equal_i     = eq;
    bus.exRd_i      = REG_W'(exrd);
    bus.exMemRead_i = exmr;
  endtask

  // One clock: check combinational outputs mid-cycle, then registered outputs just after the edge.
  task automatic step();
    bit hz;
    bit exp_stall;
    bit exp_br;
    #2;
    hz        = ref_hazard();
    exp_stall = (busy_left > 0) || hz;
    exp_br    = (busy_left == 0) && !hz && (bus.opCode_i == OP_BRANCH) && bus.equal_i;
    chk("stall",   8'(bus.stall_o),   8'(exp_stall));
    chk("branch",  8'(bus.branch_o),  8'(exp_br));
    chk("flush",   8'(bus.flush_o),   8'(exp_br));
    chk("mulbusy", 8'(bus.mulBusy_o), 8'(busy_left > 0));
    @(posedge clk_i);
    #1;
    if (busy_left > 0) begin
      busy_left--;
    end else if (hz) begin
      ctrl_m = '0;
    end else begin
      ctrl_m = ref_dec(bus.opCode_i);
      if (MULTI && (bus.opCode_i == OP_R) && (bus.funct_i == FN_MUL) && (MUL_CYCLES > 1))
        busy_left = MUL_CYCLES - 1;
    end
    chk("ex_ctrl", obs_ctrl(), ctrl_m);
  endtask

  initial begin
    drive(OP_R, 10'd0, 1, 2, 1'b0, 0, 1'b0);
    #7;
    chk("rst_ctrl",    obs_ctrl(),        8'h00);
    chk("rst_stall",   8'(bus.stall_o),   8'h00);
    chk("rst_mulbusy", 8'(bus.mulBusy_o), 8'h00);
    rst_i = 1'b0;
    step();
    chk("rtype_aluop", 8'(bus.aluOp_o),    8'h02);
    chk("rtype_regwr", 8'(bus.regWrite_o), 8'h01);

    // load-use on rs2 of a store, then the load has left EX
    drive(OP_STORE, 10'd0, 7, 5, 1'b0, 5, 1'b1);
    step();
    chk("bubble", obs_ctrl(), 8'h00);
    drive(OP_STORE, 10'd0, 7, 5, 1'b0, 0, 1'b0);
    step();
    chk("store_ctrl", obs_ctrl(), 8'h24);
    drive(OP_STORE, 10'd0, 7, 0, 1'b0, 0, 1'b1);
    step();

    // taken / not-taken branch, and branch hidden behind a load-use stall
    drive(OP_BRANCH, 10'd0, 1, 2, 1'b1, 0, 1'b0);
    step();
    drive(OP_BRANCH, 10'd0, 1, 2, 1'b0, 0, 1'b0);
    step();
    drive(OP_BRANCH, 10'd0, 3, 4, 1'b1, 3, 1'b1);
    step();
    drive(OP_BRANCH, 10'd0, 3, 4, 1'b1, 0, 1'b0);
    step();

    // mul, with a taken branch waiting in ID during the busy window
    drive(OP_R, FN_MUL, 1, 2, 1'b0, 0, 1'b0);
    step();
    drive(OP_BRANCH, 10'd0, 1, 2, 1'b1, 0, 1'b0);
    for (int i = 0; i < MUL_CYCLES + 1; i++) step();

    // async reset in the second busy cycle
    drive(OP_R, FN_MUL, 1, 2, 1'b0, 0, 1'b0);
    step();
    drive(OP_I, 10'd0, 1, 2, 1'b0, 0, 1'b0);
    step();
    rst_i = 1'b1;
    #1;
    chk("arst_mulbusy", 8'(bus.mulBusy_o), 8'h00);
    chk("arst_stall",   8'(bus.stall_o),   8'h00);
    chk("arst_ctrl",    obs_ctrl(),        8'h00);
    ctrl_m    = '0;
    busy_left = 0;
    #1;
    rst_i = 1'b0;
    step();

    // random instruction stream with a small register space so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      logic [9:0] fn;
      int         sel;
      sel = int'($urandom_range(0, 6));
      fn  = 10'($urandom);
      case (sel)
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LOAD;
        3: op = OP_STORE;
        4: op = OP_BRANCH;
        5: begin op = OP_R; fn = FN_MUL; end
        default: op = 7'($urandom);
      endcase
      drive(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
